// File: rtl/lsu_pkg.sv
// lsu_pkg: shared encodings and fault classification for the load/store unit
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [1:0] RWE_NONE = 2'd0;
    localparam logic [1:0] RWE_SB   = 2'd1;
    localparam logic [1:0] RWE_SH   = 2'd2;
    localparam logic [1:0] RWE_SW   = 2'd3;

    localparam logic [1:0] FLT_NONE     = 2'd0;
    localparam logic [1:0] FLT_MISALIGN = 2'd1;
    localparam logic [1:0] FLT_RANGE    = 2'd2;
    localparam logic [1:0] FLT_FUNCT3   = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RESP   = 2'd2
    } state_t;

    // illegal funct3 outranks misalignment, which outranks an out-of-range index
    function automatic logic [1:0] lsu_fault(input logic we, input logic [2:0] f3,
                                             input logic [31:0] addr, input logic [31:0] depth,
                                             input logic align);
        logic legal, mis;
        legal = we ? (f3 == F3_B || f3 == F3_H || f3 == F3_W)
                   : (f3 == F3_B || f3 == F3_H || f3 == F3_W || f3 == F3_BU || f3 == F3_HU);
        mis = align && ((f3[1:0] == 2'b01 && addr[0]) || (f3[1:0] == 2'b10 && addr[1:0] != 2'b00));
        return !legal ? FLT_FUNCT3 : mis ? FLT_MISALIGN : addr >= depth ? FLT_RANGE : FLT_NONE;
    endfunction

    function automatic logic [1:0] rwe_code(input logic [1:0] sz);
        return sz == 2'b00 ? RWE_SB : sz == 2'b01 ? RWE_SH : RWE_SW;
    endfunction

endpackage

// File: rtl/lsu_mem_master_if.sv
// lsu_mem_master_if: request, response and data-memory signals of the load/store unit
interface lsu_mem_master_if;

    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [4:0]  req_rd;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic [4:0]  resp_rd;
    logic [1:0]  resp_fault;
    logic [31:0] mem_a;
    logic [31:0] mem_wd;
    logic [1:0]  mem_rwe;
    logic [31:0] mem_rd;

    modport master (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata, req_rd, resp_ready, mem_rd,
        output req_ready, resp_valid, resp_rdata, resp_rd, resp_fault, mem_a, mem_wd, mem_rwe
    );

    modport slave (
        output req_valid, req_we, req_funct3, req_addr, req_wdata, req_rd, resp_ready, mem_rd,
        input  req_ready, resp_valid, resp_rdata, resp_rd, resp_fault, mem_a, mem_wd, mem_rwe
    );

endinterface

// File: rtl/lsu_load_ext.sv
// lsu_load_ext: sign/zero-extends a raw memory word according to the load funct3
module lsu_load_ext
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [31:0] raw,
    output logic [31:0] data
);

    // select the byte/half/word and fill the upper bits by funct3
    always_comb begin
        data = funct3 == F3_B  ? {{24{raw[7]}}, raw[7:0]}   :
               funct3 == F3_BU ? {24'd0, raw[7:0]}          :
               funct3 == F3_H  ? {{16{raw[15]}}, raw[15:0]} :
               funct3 == F3_HU ? {16'd0, raw[15:0]}         : raw;
    end

endmodule

// File: rtl/lsu_mem_master.sv
// lsu_mem_master: single-outstanding load/store initiator on the data-memory port
module lsu_mem_master
    import lsu_pkg::*;
#(
    parameter int MEM_DEPTH   = 64,
    parameter bit CHECK_ALIGN = 1,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    lsu_mem_master_if.master bus,
    output logic [CNT_W-1:0] cnt_load,
    output logic [CNT_W-1:0] cnt_store,
    output logic [CNT_W-1:0] cnt_fault
);

    state_t      st;
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] ext;
    logic [1:0]  req_flt;

    lsu_load_ext u_ext (
        .funct3(f3),
        .raw   (bus.mem_rd),
        .data  (ext)
    );

    assign req_flt       = lsu_fault(bus.req_we, bus.req_funct3, bus.req_addr, 32'(MEM_DEPTH), CHECK_ALIGN);
    assign bus.req_ready = st == S_IDLE;
    assign bus.mem_a     = addr;
    assign bus.mem_wd    = wdata;

    // write strobe only in the store access cycle, and never while reset is held
    always_comb begin
        bus.mem_rwe = (!rst && st == S_ACCESS && we) ? rwe_code(f3[1:0]) : RWE_NONE;
    end

    // request latch, access, response hold and event counting
    always_ff @(posedge clk) begin
        if (rst) begin
            st             <= S_IDLE;
            we             <= 1'b0;
            f3             <= 3'd0;
            addr           <= 32'd0;
            wdata          <= 32'd0;
            bus.resp_valid <= 1'b0;
            bus.resp_rdata <= 32'd0;
            bus.resp_rd    <= 5'd0;
            bus.resp_fault <= FLT_NONE;
            cnt_load       <= '0;
            cnt_store      <= '0;
            cnt_fault      <= '0;
        end else begin
            case (st)
                S_IDLE: if (bus.req_valid) begin
                    we             <= bus.req_we;
                    f3             <= bus.req_funct3;
                    addr           <= bus.req_addr;
                    wdata          <= bus.req_wdata;
                    bus.resp_rd    <= bus.req_rd;
                    bus.resp_fault <= req_flt;
                    bus.resp_rdata <= 32'd0;
                    bus.resp_valid <= req_flt != FLT_NONE;
                    st             <= req_flt != FLT_NONE ? S_RESP : S_ACCESS;
                end
                S_ACCESS: begin
                    bus.resp_rdata <= we ? 32'd0 : ext;
                    bus.resp_valid <= 1'b1;
                    st             <= S_RESP;
                end
                S_RESP: if (bus.resp_ready) begin
                    bus.resp_valid <= 1'b0;
                    st             <= S_IDLE;
                    if (bus.resp_fault != FLT_NONE)
                        cnt_fault <= cnt_fault + CNT_W'(cnt_fault != '1);
                    else if (we)
                        cnt_store <= cnt_store + CNT_W'(cnt_store != '1);
                    else
                        cnt_load <= cnt_load + CNT_W'(cnt_load != '1);
                end
                default: st <= S_IDLE;
            endcase
        end
    end

endmodule
